// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, default
// timing/depth constants and the status register bit layout.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 37;  // 4.29 MHz / 115200 baud
   localparam int DEFAULT_FIFO_DEPTH   = 4;
   localparam int DATA_BITS            = 8;

   // Status register bit positions seen by the 6809
   localparam int STAT_FIFO_EMPTY = 0;
   localparam int STAT_FIFO_FULL  = 1;
   localparam int STAT_BUSY       = 2;
   localparam int STAT_OVERFLOW   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Width of a counter/pointer that must index n distinct values
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Assemble the status byte from the individual flags
   function automatic logic [7:0] status_byte(input logic empty,
                                              input logic full,
                                              input logic busy,
                                              input logic overflow);
      logic [7:0] s;
      s                  = '0;
      s[STAT_FIFO_EMPTY] = empty;
      s[STAT_FIFO_FULL]  = full;
      s[STAT_BUSY]       = busy;
      s[STAT_OVERFLOW]   = overflow;
      return s;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering bytes between the CPU data register and
// the serialiser. Pushes into a full FIFO and pops from an empty one are
// ignored; a push and pop in the same cycle leave the occupancy unchanged.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int WIDTH = DATA_BITS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = cnt_width(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_push;
   logic w_pop;

   // Wrap a pointer at DEPTH-1 explicitly so any depth indexes correctly
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_data  = r_mem[r_rd_ptr];

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      // NOTE: state updates use <= so every register samples pre-edge values.
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array
   always_ff @(posedge clk) begin
      // NOTE: the array is not reset; an empty count makes stale entries unreachable.
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: bytes written by the CPU queue in a small FIFO and
// are shifted out LSB first on o_UART_RX, each bit held CLKS_PER_BIT clocks.
// A frame pops the FIFO head on the IDLE cycle, so back-to-back frames are
// spaced by exactly one idle cycle.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_write,
   input  logic                 i_clear_overflow,
   output logic                 o_UART_RX,
   output logic                 o_busy,
   output logic                 o_fifo_full,
   output logic                 o_fifo_empty,
   output logic                 o_overflow,
   output logic                 o_tx_done
);

   localparam int BAUD_W = cnt_width(CLKS_PER_BIT);
   localparam int BIT_W  = cnt_width(DATA_BITS);

   tx_state_t            r_state;
   tx_state_t            w_state_next;
   logic [BAUD_W-1:0]    r_baud_cnt;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_tx;
   logic                 r_overflow;

   logic [DATA_BITS-1:0] w_fifo_data;
   logic                 w_pop;
   logic                 w_bit_end;
   logic                 w_last_bit;
   logic                 w_tx_next;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (i_write),
      .i_data  (i_data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (o_fifo_full),
      .o_empty (o_fifo_empty)
   );

   assign w_bit_end  = (r_baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
   assign w_last_bit = (r_bit_cnt == BIT_W'(DATA_BITS - 1));

   assign o_UART_RX  = r_tx;
   assign o_overflow = r_overflow;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // FSM next-state logic
   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      w_state_next = r_state;
      case (r_state)
         IDLE:  if (!o_fifo_empty)           w_state_next = START;
         START: if (w_bit_end)               w_state_next = DATA;
         DATA:  if (w_bit_end && w_last_bit) w_state_next = STOP;
         STOP:  if (w_bit_end)               w_state_next = IDLE;
         default:                            w_state_next = IDLE;
      endcase
   end

   // FSM outputs: FIFO pop, status and the next serial line level
   always_comb begin
      w_pop     = 1'b0;
      w_tx_next = 1'b1;
      o_busy    = (r_state != IDLE);
      o_tx_done = (r_state == STOP) && w_bit_end;
      if (r_state == IDLE && !o_fifo_empty) w_pop = 1'b1;
      case (w_state_next)
         START:   w_tx_next = 1'b0;
         // On a data-bit boundary the shifter moves this edge, so look one bit ahead
         DATA:    w_tx_next = (r_state == DATA && w_bit_end) ? r_shift[1] : r_shift[0];
         default: w_tx_next = 1'b1;
      endcase
   end

   // Baud counter: restarts at every bit boundary and rests at zero in IDLE
   always_ff @(posedge clk) begin
      if (reset)                             r_baud_cnt <= '0;
      else if (r_state == IDLE || w_bit_end) r_baud_cnt <= '0;
      else                                   r_baud_cnt <= r_baud_cnt + 1'b1;
   end

   // Data-bit counter: advances once per data bit, cleared outside DATA
   always_ff @(posedge clk) begin
      if (reset)                 r_bit_cnt <= '0;
      else if (r_state != DATA)  r_bit_cnt <= '0;
      else if (w_bit_end)        r_bit_cnt <= r_bit_cnt + 1'b1;
   end

   // Shift register: loaded from the FIFO head on pop, shifted right per data bit
   always_ff @(posedge clk) begin
      if (reset)                           r_shift <= '0;
      else if (w_pop)                      r_shift <= w_fifo_data;
      else if (r_state == DATA && w_bit_end) r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
   end

   // Registered serial line keeps o_UART_RX glitch-free; idles high
   always_ff @(posedge clk) begin
      if (reset) r_tx <= 1'b1;
      else       r_tx <= w_tx_next;
   end

   // Sticky overflow: a write into a full FIFO sets it and beats a same-cycle clear
   always_ff @(posedge clk) begin
      if (reset)                        r_overflow <= 1'b0;
      else if (i_write && o_fifo_full)  r_overflow <= 1'b1;
      else if (i_clear_overflow)        r_overflow <= 1'b0;
   end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 37, clk cycles per serial bit (4.29 MHz / 115200).
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, at least 2).
REQ-003 clk  input  1  system clock from the internal oscillator; one clock only, all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_data  input  8  byte written by the 6809 data-register access.
REQ-006 i_write  input  1  one-cycle, clk-synchronous strobe that enqueues i_data.
REQ-007 i_clear_overflow  input  1  one-cycle strobe that clears o_overflow.
REQ-008 o_UART_RX  output  1  serial line to the FT2232 RX pin; idle high.
REQ-009 o_busy  output  1  high while a frame is being shifted out.
REQ-010 o_fifo_full / o_fifo_empty  output  1 each  FIFO status bits for the UART status register.
REQ-011 o_overflow  output  1  sticky flag: a write was dropped.
REQ-012 o_tx_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-013 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE->START when the FIFO is not empty.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after 8 bits.
- STOP->IDLE after CLKS_PER_BIT cycles.
REQ-015 Write timing: i_write asserted in cycle N with FIFO not full stores i_data; the entry is visible (o_fifo_empty=0) in cycle N+1.
REQ-016 Start latency: from IDLE with the FIFO non-empty in cycle M, the FSM pops the head in M; o_UART_RX goes low and o_busy goes high in M+1.
REQ-017 Back-to-back frames: if the FIFO is non-empty when STOP completes, IDLE lasts exactly one cycle before the next START, giving a 10*CLKS_PER_BIT+1 cycle frame pitch.
REQ-018 Full FIFO: i_write while full SHALL be dropped and o_overflow set the next cycle, even if a pop occurs in the same cycle.
REQ-019 Simultaneous push and pop when not full or empty: both occur, and the occupancy count is unchanged.
REQ-020 Push into an empty FIFO while the FSM is IDLE: the push takes effect and the pop follows in the next cycle per REQ-016.
REQ-021 Pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter is log2(FIFO_DEPTH)+1 bits wide and never exceeds FIFO_DEPTH.
REQ-022 o_overflow SHALL stay set until i_clear_overflow is asserted; if i_clear_overflow and a new overflow occur in the same cycle, set wins.
REQ-023 o_tx_done SHALL pulse in the last cycle of STOP.
REQ-024 o_UART_RX SHALL be driven from a register, so it is glitch-free.

Reset
REQ-025 On reset the block SHALL enter IDLE and drive:
- o_UART_RX=1, o_busy=0, o_fifo_empty=1, o_fifo_full=0, o_overflow=0, o_tx_done=0.
- pointers, counters and shift register cleared.
REQ-026 Reset during a frame SHALL abort it: the line is high from the next cycle, and FIFO contents are discarded.

Structure
REQ-027 Shared package uart_pkg SHALL hold:
- the tx state enum;
- default CLKS_PER_BIT and FIFO_DEPTH constants;
- the UART status bit positions.
REQ-028 The FIFO SHALL be a sub-module, uart_tx_fifo, with push/pop/full/empty ports.
REQ-029 The baud counter, bit counter and shift register SHALL live in uart_transmitter.

Verification
REQ-030 With CLKS_PER_BIT=4, write 0x55 from idle: line low 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles; o_tx_done pulses once, 41 cycles after the write.
REQ-031 Write 0xA3 and 0x0F in consecutive cycles: two frames, 0xA3 first; second start bit exactly one cycle after the first stop bit ends.
REQ-032 Write 0x01, then 5 writes (0x10..0x14) once the line is low: 0x10..0x13 accepted, o_fifo_full=1, 0x14 dropped, o_overflow=1; transmitted sequence is 0x01,0x10..0x13.
REQ-033 Assert reset at data bit 3 of 0xFF: o_UART_RX=1 next cycle, o_fifo_empty=1, and no o_tx_done pulse.
REQ-034 Assert i_clear_overflow together with a write into a full FIFO: o_overflow stays 1; a later i_clear_overflow alone clears it.
